// File: rtl/pipe_front_ctrl.sv
// Front-end pipeline control: PC and IF/ID register, stall/flush handling,
// ECALL-halt drain sequencing and stall/flush performance counters.
module pipe_front_ctrl #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_PC     = {XLEN{1'b0}},
   parameter int              DRAIN_CYCLES = 3,
   parameter int              CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             hz_stall,
   input  logic             flush_req,
   input  logic [XLEN-1:0]  flush_target,
   input  logic [XLEN-1:0]  next_pc_seq,
   input  logic             halt_req,
   input  logic [31:0]      if_inst,
   output logic [XLEN-1:0]  pc,
   output logic [31:0]      if_id_inst,
   output logic [XLEN-1:0]  if_id_pc,
   output logic             if_id_valid,
   output logic             id_ex_bubble,
   output logic             is_halted,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   localparam logic [31:0] NOP        = 32'h0000_0013;
   localparam logic [7:0]  DRAIN_INIT = 8'(DRAIN_CYCLES);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [31:0]       inst_q, inst_d;
   logic [XLEN-1:0]   ifpc_q, ifpc_d;
   logic              valid_q, valid_d;
   logic              halted_q, halted_d;
   logic [7:0]        drain_q, drain_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
   logic [1:0]        unused_tgt_lo;

   // Counters stick at all-ones so long runs never report a small wrapped value.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      sat_inc = (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   assign unused_tgt_lo = flush_target[1:0];

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      inst_d      = inst_q;
      ifpc_d      = ifpc_q;
      valid_d     = valid_q;
      halted_d    = halted_q;
      drain_d     = drain_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      case (state_q)
         ST_RUN: begin
            if (flush_req) begin
               pc_d        = {flush_target[XLEN-1:2], 2'b00};
               inst_d      = NOP;
               valid_d     = 1'b0;
               flush_cnt_d = sat_inc(flush_cnt_q);
            end else if (hz_stall) begin
               stall_cnt_d = sat_inc(stall_cnt_q);
            end else if (halt_req && valid_q) begin
               // ECALL moves on to ID/EX; IF/ID empties while older instrs retire.
               inst_d  = NOP;
               valid_d = 1'b0;
               state_d = ST_DRAIN;
               drain_d = DRAIN_INIT;
            end else begin
               pc_d    = next_pc_seq;
               inst_d  = if_inst;
               ifpc_d  = pc_q;
               valid_d = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (drain_q <= 8'd1) begin
               state_d  = ST_HALTED;
               halted_d = 1'b1;
               drain_d  = 8'd0;
            end else begin
               drain_d = drain_q - 8'd1;
            end
         end
         ST_HALTED: begin
            halted_d = 1'b1;
         end
         default: begin
            state_d = ST_HALTED;
         end
      endcase
   end

   // State register for the whole front end.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_RUN;
         pc_q        <= RESET_PC;
         inst_q      <= NOP;
         ifpc_q      <= {XLEN{1'b0}};
         valid_q     <= 1'b0;
         halted_q    <= 1'b0;
         drain_q     <= 8'd0;
         stall_cnt_q <= {CNT_W{1'b0}};
         flush_cnt_q <= {CNT_W{1'b0}};
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         inst_q      <= inst_d;
         ifpc_q      <= ifpc_d;
         valid_q     <= valid_d;
         halted_q    <= halted_d;
         drain_q     <= drain_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign pc           = pc_q;
   assign if_id_inst   = inst_q;
   assign if_id_pc     = ifpc_q;
   assign if_id_valid  = valid_q;
   assign is_halted    = halted_q;
   assign stall_cycles = stall_cnt_q;
   assign flush_count  = flush_cnt_q;
   // The halt-accept cycle naturally yields 0 here: RUN, no stall/flush, ID valid.
   assign id_ex_bubble = (state_q != ST_RUN) | hz_stall | flush_req | ~valid_q;

endmodule

// File: tb/tb_pipe_front_ctrl.sv
// Scoreboard bench for pipe_front_ctrl: directed steps push hand-computed
// expectations, a monitor pops and compares each cycle.
module tb_pipe_front_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        hz_stall, flush_req, halt_req;
   logic [31:0] flush_target, next_pc_seq, if_inst;
   logic [31:0] pc, if_id_inst, if_id_pc, stall_cycles, flush_count;
   logic        if_id_valid, id_ex_bubble, is_halted;
   logic [31:0] pc2, if_id_inst2, if_id_pc2;
   logic        if_id_valid2, id_ex_bubble2, is_halted2;
   logic [1:0]  stall_cycles2, flush_count2;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        bub;
      logic [31:0] pc, ifpc, inst;
      logic        v, h;
      logic [31:0] sc, fc;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   assign next_pc_seq = pc + 32'd4;
   assign if_inst     = 32'hA000_0000 | pc;

   pipe_front_ctrl dut (
      .clk(clk), .reset(reset), .hz_stall(hz_stall), .flush_req(flush_req),
      .flush_target(flush_target), .next_pc_seq(next_pc_seq), .halt_req(halt_req),
      .if_inst(if_inst), .pc(pc), .if_id_inst(if_id_inst), .if_id_pc(if_id_pc),
      .if_id_valid(if_id_valid), .id_ex_bubble(id_ex_bubble), .is_halted(is_halted),
      .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   // Narrow-counter copy exercises saturation.
   pipe_front_ctrl #(.CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .hz_stall(hz_stall), .flush_req(flush_req),
      .flush_target(flush_target), .next_pc_seq(next_pc_seq), .halt_req(halt_req),
      .if_inst(if_inst), .pc(pc2), .if_id_inst(if_id_inst2), .if_id_pc(if_id_pc2),
      .if_id_valid(if_id_valid2), .id_ex_bubble(id_ex_bubble2), .is_halted(is_halted2),
      .stall_cycles(stall_cycles2), .flush_count(flush_count2)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step(input logic st, input logic fl, input logic [31:0] tg, input logic hl,
                       input logic bub, input logic [31:0] epc, input logic [31:0] eifpc,
                       input logic [31:0] einst, input logic ev, input logic eh,
                       input logic [31:0] esc, input logic [31:0] efc);
      exp_t e;
      @(negedge clk);
      hz_stall = st; flush_req = fl; flush_target = tg; halt_req = hl;
      e.bub = bub; e.pc = epc; e.ifpc = eifpc; e.inst = einst;
      e.v = ev; e.h = eh; e.sc = esc; e.fc = efc;
      sb.push_back(e);
   endtask

   // Monitor: bubble is checked mid-cycle, registered outputs just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("bubble", {31'd0, id_ex_bubble}, {31'd0, e.bub});
            @(posedge clk);
            #1;
            chk("pc", pc, e.pc);
            chk("if_id_pc", if_id_pc, e.ifpc);
            chk("if_id_inst", if_id_inst, e.inst);
            chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, e.v});
            chk("is_halted", {31'd0, is_halted}, {31'd0, e.h});
            chk("stall_cycles", stall_cycles, e.sc);
            chk("flush_count", flush_count, e.fc);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_pc"}, pc, 32'd0);
      chk({tag, "_if_id_pc"}, if_id_pc, 32'd0);
      chk({tag, "_if_id_inst"}, if_id_inst, 32'h0000_0013);
      chk({tag, "_if_id_valid"}, {31'd0, if_id_valid}, 32'd0);
      chk({tag, "_is_halted"}, {31'd0, is_halted}, 32'd0);
      chk({tag, "_stall_cycles"}, stall_cycles, 32'd0);
      chk({tag, "_flush_count"}, flush_count, 32'd0);
      chk({tag, "_bubble"}, {31'd0, id_ex_bubble}, 32'd1);
   endtask

   initial begin
      reset = 1'b0; hz_stall = 1'b0; flush_req = 1'b0; halt_req = 1'b0;
      flush_target = 32'd0;
      repeat (3) @(posedge clk);
      #2;
      chk_reset_vals("rst");
      reset = 1'b1;

      // Sequential fetch
      step(0, 0, 32'h0, 0, 1, 32'h04, 32'h00, 32'hA000_0000, 1, 0, 0, 0);
      step(0, 0, 32'h0, 0, 0, 32'h08, 32'h04, 32'hA000_0004, 1, 0, 0, 0);
      step(0, 0, 32'h0, 0, 0, 32'h0C, 32'h08, 32'hA000_0008, 1, 0, 0, 0);
      step(0, 0, 32'h0, 0, 0, 32'h10, 32'h0C, 32'hA000_000C, 1, 0, 0, 0);
      // Stalls at pc=0x10
      for (int k = 1; k <= 5; k++)
         step(1, 0, 32'h0, 0, 1, 32'h10, 32'h0C, 32'hA000_000C, 1, 0, 32'(k), 0);
      step(0, 0, 32'h0, 0, 0, 32'h14, 32'h10, 32'hA000_0010, 1, 0, 5, 0);
      // Flush beats simultaneous stall, target low bits dropped
      step(1, 1, 32'h43, 0, 1, 32'h40, 32'h10, 32'h0000_0013, 0, 0, 5, 1);
      // Halt with empty ID is ignored
      step(0, 0, 32'h0, 1, 1, 32'h44, 32'h40, 32'hA000_0040, 1, 0, 5, 1);
      @(posedge clk);
      #2;
      chk("sat_stall_cycles", {30'd0, stall_cycles2}, 32'd3);
      chk("sat_flush_count", {30'd0, flush_count2}, 32'd1);
      // Halt accept and drain
      step(0, 0, 32'h0,   1, 0, 32'h44, 32'h40, 32'h0000_0013, 0, 0, 5, 1);
      step(1, 1, 32'h100, 0, 1, 32'h44, 32'h40, 32'h0000_0013, 0, 0, 5, 1);
      step(0, 0, 32'h0,   0, 1, 32'h44, 32'h40, 32'h0000_0013, 0, 0, 5, 1);
      step(0, 0, 32'h0,   0, 1, 32'h44, 32'h40, 32'h0000_0013, 0, 1, 5, 1);
      step(0, 1, 32'h200, 0, 1, 32'h44, 32'h40, 32'h0000_0013, 0, 1, 5, 1);

      // Reset out of HALTED, then halt again and reset mid-drain
      @(posedge clk);
      #2;
      reset = 1'b0; hz_stall = 1'b0; flush_req = 1'b0; halt_req = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b1;
      step(0, 0, 32'h0, 0, 1, 32'h04, 32'h00, 32'hA000_0000, 1, 0, 0, 0);
      step(0, 0, 32'h0, 0, 0, 32'h08, 32'h04, 32'hA000_0004, 1, 0, 0, 0);
      step(0, 0, 32'h0, 1, 0, 32'h08, 32'h04, 32'h0000_0013, 0, 0, 0, 0);
      step(0, 0, 32'h0, 0, 1, 32'h08, 32'h04, 32'h0000_0013, 0, 0, 0, 0);
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk_reset_vals("mid_drain_rst");
      @(posedge clk);
      #2;
      reset = 1'b1;
      step(0, 0, 32'h0, 0, 1, 32'h04, 32'h00, 32'hA000_0000, 1, 0, 0, 0);

      @(posedge clk);
      #3;
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
